// File: rtl/serial_word_deframer.sv
// Serial-to-parallel word deframer: hunts for a sync pattern, then assembles
// WORDS_PER_FRAME MSB-first words onto a one-entry valid/ready output register.
// Optional even-parity checking per word is enabled by defining PARITY_CHECK_EN.
module serial_word_deframer #(
    parameter int unsigned WIDTH           = 8,
    parameter logic [31:0] SYNC_PATTERN    = 32'h0000_00A5,
    parameter int unsigned SYNC_LEN        = 8,
    parameter int unsigned WORDS_PER_FRAME = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_en,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             frame_sync,
    output logic             overflow,
    output logic             word_err
);

    localparam int unsigned BIT_CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned FILL_W    = $clog2(SYNC_LEN + 1);
    localparam int unsigned WCNT_W    = 8;

`ifdef PARITY_CHECK_EN
    typedef enum logic [1:0] {HUNT, DATA, PARITY} state_t;
`else
    typedef enum logic [0:0] {HUNT, DATA} state_t;
`endif

    state_t                state_q, state_d;
    logic [FILL_W-1:0]     fill_q, fill_d;
    logic [SYNC_LEN-1:0]   sync_q, sync_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WCNT_W-1:0]     word_cnt_q, word_cnt_d;
    logic [WIDTH-1:0]      word_sr_q, word_sr_d;
    logic [WIDTH-1:0]      word_out_q, word_out_d;
    logic                  word_valid_q, word_valid_d;
    logic                  frame_sync_q, frame_sync_d;
    logic                  overflow_q, overflow_d;
`ifdef PARITY_CHECK_EN
    logic                  word_err_q, word_err_d;
    logic                  done_err;
`endif

    logic                  done;
    logic [WIDTH-1:0]      done_word;
    logic [SYNC_LEN-1:0]   sync_shift;
    logic [FILL_W-1:0]     fill_inc;
    logic [WIDTH-1:0]      word_shift;

    // Next-state, counters, shift registers and output-register handshake.
    always_comb begin
        state_d      = state_q;
        fill_d       = fill_q;
        sync_d       = sync_q;
        bit_cnt_d    = bit_cnt_q;
        word_cnt_d   = word_cnt_q;
        word_sr_d    = word_sr_q;
        word_out_d   = word_out_q;
        word_valid_d = word_valid_q;
        overflow_d   = overflow_q;
        done         = 1'b0;
        done_word    = word_sr_q;
`ifdef PARITY_CHECK_EN
        word_err_d   = word_err_q;
        done_err     = 1'b0;
`endif
        sync_shift   = {sync_q[SYNC_LEN-2:0], bit_in};
        fill_inc     = (fill_q == FILL_W'(SYNC_LEN)) ? fill_q : fill_q + 1'b1;
        word_shift   = {word_sr_q[WIDTH-2:0], bit_in};

        if (bit_en) begin
            case (state_q)
                HUNT: begin
                    sync_d = sync_shift;
                    fill_d = fill_inc;
                    if (fill_inc == FILL_W'(SYNC_LEN) &&
                        sync_shift == SYNC_PATTERN[SYNC_LEN-1:0]) begin
                        state_d    = DATA;
                        bit_cnt_d  = '0;
                        word_cnt_d = '0;
                    end
                end
                DATA: begin
                    word_sr_d = word_shift;
                    if (bit_cnt_q == BIT_CNT_W'(WIDTH - 1)) begin
                        bit_cnt_d = '0;
`ifdef PARITY_CHECK_EN
                        state_d   = PARITY;
`else
                        done      = 1'b1;
                        done_word = word_shift;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
`ifdef PARITY_CHECK_EN
                PARITY: begin
                    done      = 1'b1;
                    done_word = word_sr_q;
                    done_err  = (^word_sr_q) ^ bit_in;
                    state_d   = DATA;
                end
`endif
                default: state_d = HUNT;
            endcase
        end

        // A completed word counts toward the frame even when it is dropped.
        if (done) begin
            word_cnt_d = word_cnt_q + 1'b1;
            if (word_cnt_q == WCNT_W'(WORDS_PER_FRAME - 1)) begin
                state_d = HUNT;
                fill_d  = '0;
                sync_d  = '0;
            end
        end

        if (done) begin
            if (!word_valid_q || word_ready) begin
                word_out_d   = done_word;
                word_valid_d = 1'b1;
`ifdef PARITY_CHECK_EN
                word_err_d   = done_err;
`endif
            end else begin
                overflow_d = 1'b1;
            end
        end else if (word_valid_q && word_ready) begin
            word_valid_d = 1'b0;
        end

        frame_sync_d = (state_d != HUNT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= HUNT;
            fill_q       <= '0;
            sync_q       <= '0;
            bit_cnt_q    <= '0;
            word_cnt_q   <= '0;
            word_sr_q    <= '0;
            word_out_q   <= '0;
            word_valid_q <= 1'b0;
            frame_sync_q <= 1'b0;
            overflow_q   <= 1'b0;
`ifdef PARITY_CHECK_EN
            word_err_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            fill_q       <= fill_d;
            sync_q       <= sync_d;
            bit_cnt_q    <= bit_cnt_d;
            word_cnt_q   <= word_cnt_d;
            word_sr_q    <= word_sr_d;
            word_out_q   <= word_out_d;
            word_valid_q <= word_valid_d;
            frame_sync_q <= frame_sync_d;
            overflow_q   <= overflow_d;
`ifdef PARITY_CHECK_EN
            word_err_q   <= word_err_d;
`endif
        end
    end

    assign word_out   = word_out_q;
    assign word_valid = word_valid_q;
    assign frame_sync = frame_sync_q;
    assign overflow   = overflow_q;
`ifdef PARITY_CHECK_EN
    assign word_err   = word_err_q;
`else
    assign word_err   = 1'b0;
`endif

endmodule

// File: tb/tb_serial_word_deframer.sv
// Bench for serial_word_deframer: directed scenarios plus random traffic,
// checked every cycle against a queue-based frame model.
module tb_serial_word_deframer;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned SLEN  = 8;
    localparam int unsigned WPF   = 4;
    localparam logic [7:0]  PAT   = 8'hA5;
`ifdef PARITY_CHECK_EN
    localparam int unsigned PB = 1;
`else
    localparam int unsigned PB = 0;
`endif
    localparam int unsigned FRAME_BITS = WPF * (WIDTH + PB);

    logic             clk;
    logic             rst;
    logic             bit_in;
    logic             bit_en;
    logic [WIDTH-1:0] word_out;
    logic             word_valid;
    logic             word_ready;
    logic             frame_sync;
    logic             overflow;
    logic             word_err;

    serial_word_deframer dut (
        .clk        (clk),
        .rst        (rst),
        .bit_in     (bit_in),
        .bit_en     (bit_en),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .frame_sync (frame_sync),
        .overflow   (overflow),
        .word_err   (word_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_on = 1'b0;
    bit fs_cnt_on = 1'b0;
    int fs_cnt = 0;
    logic [WIDTH-1:0] seen[$];
    logic             seen_err[$];

    // Reference model state: hunt history and current word as bit queues.
    bit               m_in_frame;
    bit               hist[$];
    bit               cur[$];
    int               m_wcnt;
    logic [WIDTH-1:0] m_word;
    logic             m_valid, m_ovf, m_err, m_fs;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input logic b, input logic en, input logic rdy, input logic r);
        logic [7:0]       v;
        logic [WIDTH-1:0] w;
        logic             e;
        bit               deliver;
        if (r) begin
            m_in_frame = 1'b0;
            hist.delete();
            cur.delete();
            m_wcnt  = 0;
            m_word  = '0;
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            m_err   = 1'b0;
            m_fs    = 1'b0;
            return;
        end
        deliver = 1'b0;
        w = '0;
        e = 1'b0;
        if (en) begin
            if (!m_in_frame) begin
                hist.push_back(b);
                if (hist.size() > SLEN) void'(hist.pop_front());
                if (hist.size() == SLEN) begin
                    v = '0;
                    for (int i = 0; i < int'(SLEN); i++) v = {v[6:0], hist[i]};
                    if (v == PAT) begin
                        m_in_frame = 1'b1;
                        cur.delete();
                        m_wcnt = 0;
                    end
                end
            end else begin
                cur.push_back(b);
                if (cur.size() == WIDTH + PB) begin
                    for (int i = 0; i < int'(WIDTH); i++) w = {w[WIDTH-2:0], cur[i]};
                    if (PB != 0) foreach (cur[i]) e = e ^ cur[i];
                    deliver = 1'b1;
                    cur.delete();
                    m_wcnt++;
                    if (m_wcnt == int'(WPF)) begin
                        m_in_frame = 1'b0;
                        hist.delete();
                    end
                end
            end
        end
        if (deliver) begin
            if (!m_valid || rdy) begin
                m_word  = w;
                m_err   = e;
                m_valid = 1'b1;
            end else begin
                m_ovf = 1'b1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        m_fs = m_in_frame;
    endtask

    // One clock: compare at the falling edge, drive inputs, then step the model.
    task automatic cycle(input logic b, input logic en, input logic rdy, input logic r);
        @(negedge clk);
        if (chk_on) begin
            chk("word_valid", 32'(word_valid), 32'(m_valid));
            chk("frame_sync", 32'(frame_sync), 32'(m_fs));
            chk("overflow",   32'(overflow),   32'(m_ovf));
            chk("word_out",   32'(word_out),   32'(m_word));
            chk("word_err",   32'(word_err),   32'(m_err));
        end
        if (fs_cnt_on && frame_sync) fs_cnt++;
        if (word_valid && rdy) begin
            seen.push_back(word_out);
            seen_err.push_back(word_err);
        end
        bit_in     = b;
        bit_en     = en;
        word_ready = rdy;
        rst        = r;
        @(posedge clk);
        model_step(b, en, rdy, r);
    endtask

    // gap: 0 = bit_en held high, 1 = alternating, 2 = random idle cycles.
    task automatic send_bits(input logic [31:0] v, input int n, input logic rdy, input int gap);
        for (int i = n - 1; i >= 0; i--) begin
            cycle(v[i], 1'b1, rdy, 1'b0);
            if (gap == 1 || (gap == 2 && ($urandom % 3) == 0))
                cycle(1'($urandom), 1'b0, rdy, 1'b0);
        end
    endtask

    task automatic send_word(input logic [WIDTH-1:0] v, input logic par, input logic rdy, input int gap);
        send_bits(32'(v), int'(WIDTH), rdy, gap);
        if (PB != 0) send_bits(32'(par), 1, rdy, gap);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cycle(1'($urandom), 1'b0, rdy, 1'b0);
    endtask

    task automatic send_frame(input logic rdy, input int gap);
        send_bits(32'(PAT), int'(SLEN), rdy, gap);
        send_word(8'h3C, ^8'h3C, rdy, gap);
        send_word(8'h5A, ^8'h5A, rdy, gap);
        send_word(8'hFF, ^8'hFF, rdy, gap);
        send_word(8'h00, ^8'h00, rdy, gap);
    endtask

    task automatic check_seen(input string tag);
        chk({tag, "_count"}, 32'(seen.size()), 32'd4);
        if (seen.size() == 4) begin
            chk({tag, "_w0"}, 32'(seen[0]), 32'h3C);
            chk({tag, "_w1"}, 32'(seen[1]), 32'h5A);
            chk({tag, "_w2"}, 32'(seen[2]), 32'hFF);
            chk({tag, "_w3"}, 32'(seen[3]), 32'h00);
        end
    endtask

    initial begin
        bit_in = 1'b0; bit_en = 1'b0; word_ready = 1'b0; rst = 1'b1;
        model_step(1'b0, 1'b0, 1'b0, 1'b1);

        // Reset held two cycles with live serial input.
        cycle(1'($urandom), 1'b1, 1'b1, 1'b1);
        chk_on = 1'b1;
        cycle(1'($urandom), 1'b1, 1'b1, 1'b1);
        #1;
        chk("rst_word_out",   32'(word_out),   32'h0);
        chk("rst_word_valid", 32'(word_valid), 32'h0);
        chk("rst_frame_sync", 32'(frame_sync), 32'h0);
        chk("rst_overflow",   32'(overflow),   32'h0);

        // Nominal frame with an always-ready consumer.
        idle(3, 1'b1);
        seen.delete(); seen_err.delete();
        fs_cnt = 0; fs_cnt_on = 1'b1;
        send_frame(1'b1, 0);
        idle(4, 1'b1);
        fs_cnt_on = 1'b0;
        chk("nom_fs_len", 32'(fs_cnt), 32'(FRAME_BITS));
        chk("nom_ovf", 32'(overflow), 32'h0);
        check_seen("nom");

        // Backpressure: first word held, later words dropped.
        send_frame(1'b0, 0);
        idle(3, 1'b0);
        #1;
        chk("bp_word",  32'(word_out),   32'h3C);
        chk("bp_valid", 32'(word_valid), 32'h1);
        chk("bp_ovf",   32'(overflow),   32'h1);
        chk("bp_fsync", 32'(frame_sync), 32'h0);
        idle(3, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 1'b1);

        // Gapped input, bit_en alternating.
        seen.delete(); seen_err.delete();
        send_frame(1'b1, 1);
        idle(4, 1'b1);
        check_seen("gap");

        // Reset mid-word, then a partial pattern prefix before a full sync.
        send_bits(32'(PAT), int'(SLEN), 1'b1, 0);
        send_bits(32'h3, 4, 1'b1, 0);
        cycle(1'b0, 1'b1, 1'b1, 1'b1);
        #1;
        chk("mid_rst_valid", 32'(word_valid), 32'h0);
        chk("mid_rst_fsync", 32'(frame_sync), 32'h0);
        send_bits(32'h5, 4, 1'b1, 0);
        send_bits(32'(PAT >> 1), int'(SLEN) - 1, 1'b1, 0);
        #1;
        chk("mid_pre_sync", 32'(frame_sync), 32'h0);
        send_bits(32'(PAT), 1, 1'b1, 0);
        #1;
        chk("mid_sync", 32'(frame_sync), 32'h1);
        for (int i = 0; i < int'(WPF); i++) send_word(8'(i * 37), 1'b0, 1'b1, 0);
        idle(3, 1'b1);

`ifdef PARITY_CHECK_EN
        // Parity errors flagged per word.
        seen.delete(); seen_err.delete();
        send_bits(32'(PAT), int'(SLEN), 1'b1, 0);
        send_word(8'h3C, 1'b1, 1'b1, 0);
        send_word(8'h5A, 1'b0, 1'b1, 0);
        send_word(8'h11, 1'b0, 1'b1, 0);
        send_word(8'h22, 1'b0, 1'b1, 0);
        idle(3, 1'b1);
        chk("par_count", 32'(seen.size()), 32'd4);
        if (seen.size() == 4) begin
            chk("par_err0", 32'(seen_err[0]), 32'h1);
            chk("par_err1", 32'(seen_err[1]), 32'h0);
            chk("par_w0",   32'(seen[0]),     32'h3C);
        end
`endif

        // Random traffic: sync patterns mixed with noise, gaps, stalls, resets.
        for (int k = 0; k < 60; k++) begin
            if (($urandom % 8) == 0) cycle(1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
            if (($urandom % 4) == 0) send_bits($urandom, int'($urandom_range(1, 12)), 1'($urandom), 2);
            send_bits(32'(PAT), int'(SLEN), 1'($urandom), 2);
            for (int i = 0; i < int'(FRAME_BITS) + int'($urandom % 6); i++)
                cycle(1'($urandom), ($urandom % 4) != 0, ($urandom % 3) != 0,
                      ($urandom % 300) == 0);
        end
        idle(4, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
